// File: rtl/b_bus_src.sv
// ---------------------------------------------------------------------------
// b_bus_src : registered ALU B-operand source selector with buffered external feed
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module b_bus_src #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] CONST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [1:0]       b_sel,
    input  logic [WIDTH-1:0] b_reg,
    input  logic [WIDTH-1:0] ext_data,
    input  logic             ext_valid,
    output logic             ext_ready,
    output logic [WIDTH-1:0] b_bus,
    output logic             b_valid,
    output logic             stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [WIDTH-1:0]  b_bus_q;
    logic              b_valid_q;

    logic              w_push;
    logic              w_pop;
    logic              w_not_empty;
    logic              w_ext_sel;

    assign w_not_empty = (count_q != '0);
    assign w_ext_sel   = req && (b_sel == 2'b11);
    assign ext_ready   = rst_n && (count_q < CW'(DEPTH));
    assign w_push      = ext_valid && ext_ready;
    // The head is consumed only when it is actually placed on the bus.
    assign w_pop       = rst_n && w_not_empty &&
                         (((state_q == ST_IDLE) && w_ext_sel) || (state_q == ST_WAIT));
    assign count_d     = count_q + CW'(w_push) - CW'(w_pop);

    assign b_bus   = b_bus_q;
    assign b_valid = b_valid_q;
    assign stall   = rst_n && (state_q == ST_WAIT);

    // Storage is not reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= ext_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            b_bus_q   <= '0;
            b_valid_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            b_valid_q <= 1'b0;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        case (b_sel)
                            2'b00: begin
                                b_bus_q   <= b_reg;
                                b_valid_q <= 1'b1;
                            end
                            2'b01: begin
                                b_bus_q   <= '0;
                                b_valid_q <= 1'b1;
                            end
                            2'b10: begin
                                b_bus_q   <= CONST_VAL;
                                b_valid_q <= 1'b1;
                            end
                            2'b11: begin
                                if (w_not_empty) begin
                                    b_bus_q   <= mem_q[rd_ptr_q];
                                    b_valid_q <= 1'b1;
                                end else begin
                                    state_q <= ST_WAIT;
                                end
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (w_not_empty) begin
                        b_bus_q   <= mem_q[rd_ptr_q];
                        b_valid_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_b_bus_src.sv
// ---------------------------------------------------------------------------
// tb_b_bus_src : directed scoreboard bench for b_bus_src (WIDTH=8, DEPTH=2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_b_bus_src;

    localparam int          WIDTH = 8;
    localparam logic [7:0]  CVAL  = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req;
    logic [1:0]       b_sel;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic [WIDTH-1:0] b_bus;
    logic             b_valid;
    logic             stall;

    int               vectors = 0;
    int               fails   = 0;
    logic [7:0]       exp_q[$];
    logic [7:0]       last_bus = 8'h00;

    b_bus_src #(
        .WIDTH    (WIDTH),
        .DEPTH    (2),
        .CONST_VAL(CVAL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .b_sel    (b_sel),
        .b_reg    (b_reg),
        .ext_data (ext_data),
        .ext_valid(ext_valid),
        .ext_ready(ext_ready),
        .b_bus    (b_bus),
        .b_valid  (b_valid),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample #1 after the edge and score the bus output.
    task automatic tick(input string tag, input logic exp_v);
        @(posedge clk);
        #1;
        chk({tag, ".b_valid"}, {31'd0, b_valid}, {31'd0, exp_v});
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                last_bus = exp_q.pop_front();
                chk({tag, ".b_bus"}, {24'd0, b_bus}, {24'd0, last_bus});
            end
        end else begin
            chk({tag, ".b_bus_held"}, {24'd0, b_bus}, {24'd0, last_bus});
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; b_sel = 2'b00; b_reg = 8'h00;
        ext_data = 8'h00; ext_valid = 1'b0;

        // Reset and static selects
        last_bus = 8'h00;
        tick("rst0", 1'b0);
        chk("rst0.ext_ready", {31'd0, ext_ready}, 32'd0);
        chk("rst0.stall", {31'd0, stall}, 32'd0);
        tick("rst1", 1'b0);
        chk("rst1.ext_ready", {31'd0, ext_ready}, 32'd0);
        rst_n = 1'b1;
        req = 1'b1; b_reg = 8'h3C;
        b_sel = 2'b00; exp_q.push_back(8'h3C); tick("sel00", 1'b1);
        b_sel = 2'b01; exp_q.push_back(8'h00); tick("sel01", 1'b1);
        b_sel = 2'b10; exp_q.push_back(CVAL);  tick("sel10", 1'b1);
        req = 1'b0;
        tick("idle", 1'b0);

        // Buffered external
        chk("buf.ready0", {31'd0, ext_ready}, 32'd1);
        ext_valid = 1'b1; ext_data = 8'h96; tick("buf.push0", 1'b0);
        ext_data = 8'h5A; tick("buf.push1", 1'b0);
        ext_valid = 1'b0;
        chk("buf.full_ready", {31'd0, ext_ready}, 32'd0);
        req = 1'b1; b_sel = 2'b11;
        exp_q.push_back(8'h96); tick("buf.pop0", 1'b1);
        chk("buf.stall0", {31'd0, stall}, 32'd0);
        exp_q.push_back(8'h5A); tick("buf.pop1", 1'b1);
        chk("buf.stall1", {31'd0, stall}, 32'd0);
        req = 1'b0;
        #1 chk("buf.ready_empty", {31'd0, ext_ready}, 32'd1);

        // Empty-FIFO stall
        req = 1'b1; b_sel = 2'b11;
        tick("stl.c1", 1'b0); chk("stl.stall1", {31'd0, stall}, 32'd1);
        tick("stl.c2", 1'b0); chk("stl.stall2", {31'd0, stall}, 32'd1);
        tick("stl.c3", 1'b0); chk("stl.stall3", {31'd0, stall}, 32'd1);
        ext_valid = 1'b1; ext_data = 8'h96; exp_q.push_back(8'h96);
        tick("stl.c4", 1'b0); chk("stl.stall4", {31'd0, stall}, 32'd1);
        ext_valid = 1'b0; req = 1'b0;
        tick("stl.c5", 1'b1); chk("stl.stall5", {31'd0, stall}, 32'd0);

        // Full FIFO with a held producer
        ext_valid = 1'b1; ext_data = 8'h11; tick("full.p11", 1'b0);
        ext_data = 8'h22; tick("full.p22", 1'b0);
        ext_data = 8'h33;
        chk("full.ready_c2", {31'd0, ext_ready}, 32'd0);
        tick("full.hold", 1'b0);
        chk("full.ready_hold", {31'd0, ext_ready}, 32'd0);
        req = 1'b1; b_sel = 2'b11; exp_q.push_back(8'h11);
        tick("full.pop11", 1'b1);
        chk("full.ready_after_pop", {31'd0, ext_ready}, 32'd1);
        req = 1'b0;
        tick("full.acc33", 1'b0);
        ext_valid = 1'b0;
        chk("full.ready_refull", {31'd0, ext_ready}, 32'd0);
        req = 1'b1;
        exp_q.push_back(8'h22); tick("full.pop22", 1'b1);
        exp_q.push_back(8'h33); tick("full.pop33", 1'b1);
        req = 1'b0;

        // Simultaneous push and pop at count==1
        ext_valid = 1'b1; ext_data = 8'h44; tick("sim.p44", 1'b0);
        ext_data = 8'h55; req = 1'b1; b_sel = 2'b11; exp_q.push_back(8'h44);
        tick("sim.pop44", 1'b1);
        ext_valid = 1'b0;
        chk("sim.ready_c1", {31'd0, ext_ready}, 32'd1);
        exp_q.push_back(8'h55); tick("sim.pop55", 1'b1);
        chk("sim.stall", {31'd0, stall}, 32'd0);
        req = 1'b0;
        tick("sim.idle", 1'b0);

        // Reset discards buffered data, then reset during WAIT
        ext_valid = 1'b1; ext_data = 8'h77; tick("rw.p77", 1'b0);
        ext_valid = 1'b0; rst_n = 1'b0; last_bus = 8'h00;
        tick("rw.rst_a", 1'b0);
        rst_n = 1'b1; req = 1'b1; b_sel = 2'b11;
        tick("rw.enter_wait", 1'b0);
        chk("rw.stall_wait", {31'd0, stall}, 32'd1);
        req = 1'b0; rst_n = 1'b0;
        #1;
        chk("rw.stall_in_rst", {31'd0, stall}, 32'd0);
        chk("rw.ready_in_rst", {31'd0, ext_ready}, 32'd0);
        tick("rw.rst_b", 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rw.stall_after", {31'd0, stall}, 32'd0);
        chk("rw.ready_after", {31'd0, ext_ready}, 32'd1);
        ext_valid = 1'b1; ext_data = 8'h66; tick("rw.p66", 1'b0);
        ext_valid = 1'b0; req = 1'b1; b_sel = 2'b11; exp_q.push_back(8'h66);
        tick("rw.pop66", 1'b1);
        chk("rw.stall_pop", {31'd0, stall}, 32'd0);
        req = 1'b0;
        tick("rw.idle", 1'b0);

        chk("sb.drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/b_bus_src.md
# b_bus_src

Parametrised, registered B-bus source selector for the CPU datapath. It drives the ALU B operand from the register operand, zero, a build-time constant, or an external data stream. External data is buffered in a small FIFO behind a valid/ready handshake. When the CPU requests external data and none is buffered, the block stalls the CPU until data arrives.

## Interface
Parameters:
- WIDTH, 8, data width of all data ports and the bus
- DEPTH, 2, external-data FIFO depth in entries; power of two, ≥2
- CONST_VAL, 8'h00, value driven for the constant source; WIDTH bits

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  reset; synchronous, active-low
- req  input  1  CPU requests a B-bus transfer this cycle
- b_sel  input  2  source: 00 b_reg, 01 zero, 10 CONST_VAL, 11 external FIFO
- b_reg  input  WIDTH  register-file operand
- ext_data  input  WIDTH  external data word
- ext_valid  input  1  ext_data valid
- ext_ready  output  1  FIFO can accept a word
- b_bus  output  WIDTH  registered B-bus value
- b_valid  output  1  b_bus updated this cycle (one-cycle pulse)
- stall  output  1  CPU must hold req/b_sel; block waiting for external data

## Operation
- Push rules
  - Push when ext_valid && ext_ready.
  - ext_ready = rst_n && (count < DEPTH).
  - No push while full, even in a cycle that pops.
- Pop rules
  - Pop only when the FIFO is read for the bus.
  - Order is FIFO.
  - count is updated for a push and a pop in the same cycle; net change is 0.
- States: IDLE, WAIT.
- IDLE with req=1:
  - b_sel 00: b_bus<=b_reg, b_valid<=1.
  - b_sel 01: b_bus<=0, b_valid<=1.
  - b_sel 10: b_bus<=CONST_VAL, b_valid<=1.
  - b_sel 11 with count>0: pop the head, b_bus<=head, b_valid<=1.
  - b_sel 11 with count==0: go to WAIT, b_valid<=0, b_bus held.
- IDLE with req=0: b_valid<=0, b_bus held.
- WAIT:
  - stall=1 combinationally; req and b_sel are ignored.
  - When count>0: pop the head, b_bus<=head, b_valid<=1, go to IDLE.
  - A word pushed in WAIT cycle k is visible (count>0) at k+1. It is popped at k+1 and appears on b_bus at k+2.
- stall is 0 in IDLE. It is a function of state only, with no combinational path from req.
- FIFO storage is WIDTH×DEPTH; pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Timing
- Reset (rst_n=0 at a rising edge):
  - State values: state=IDLE, count=0, pointers=0, b_bus=0, b_valid=0.
  - stall=0 and ext_ready=0 while rst_n=0.
  - FIFO contents are undefined and never observable.
- Reset mid-WAIT or with FIFO occupied discards all buffered data; the block resumes in IDLE.
- Latency:
  - Non-external sources: req at cycle n → b_bus/b_valid at n+1.
  - External, buffered: req at n → n+1.
  - External, empty: req at n → WAIT from n+1 → output one cycle after the first cycle with count>0.
- Back-to-back: req every cycle gives b_valid every cycle, provided data is available.
- Empty/full boundaries:
  - Pop with count==0 never occurs.
  - Push while full is refused (ext_ready=0); the producer must hold ext_valid/ext_data.
- Simultaneous events:
  - Push and pop in the same cycle with count==1: the popped word is the old head; count stays 1.
  - Push and pop in the same cycle with count==DEPTH: no push; count goes to DEPTH-1.
- Arithmetic: no widening or sign handling; values pass through unchanged at WIDTH bits.

## Test plan
- Reset then static selects:
  - Stimulus: rst_n low 2 cycles; then req=1 with b_reg=8'h3C, b_sel=00,01,10 on consecutive cycles; CONST_VAL=8'hA5.
  - Response: b_bus=00 with b_valid=0 and ext_ready=0 during reset. Then b_bus=3C, 00, A5 on consecutive cycles with b_valid=1 each.
- Buffered external:
  - Stimulus: push 8'h96 then 8'h5A; then req, b_sel=11 twice.
  - Response: b_bus=96 then 5A with no stall; count returns to 0.
- Empty-FIFO stall:
  - Stimulus: req, b_sel=11 at cycle 0 with FIFO empty; push 8'h96 at cycle 3.
  - Response: stall=1 in cycles 1–4; pop at 4; b_bus=96 with b_valid=1 at 5; stall=0 at 5.
- Full FIFO (DEPTH=2):
  - Stimulus: push 11, 22 while ext_valid stays high with 33.
  - Response: ext_ready=0 at count=2. After a pop of 11, ext_ready=1 the following cycle, 33 is accepted, and later pops return 22 then 33.
- Simultaneous push and pop:
  - Stimulus: count=1 (head 44); req, b_sel=11 while pushing 55.
  - Response: b_bus=44, count stays 1, next pop returns 55.
- Reset during WAIT:
  - Stimulus: enter WAIT, then rst_n=0 for 1 cycle.
  - Response: state IDLE, stall=0, b_bus=0, count=0. A word 66 pushed after reset is returned by the next b_sel=11 request.
